// File: rtl/fc_argmax.sv
// Argmax back end for the fully connected layer: buffers one score vector,
// scans it one class per cycle and returns the winning index/score over valid/ready.
module fc_argmax #(
  parameter int CLASS_NUM = 30,
  parameter int D_WL      = 16,
  parameter int IDX_WL    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [CLASS_NUM*D_WL-1:0] f_o,
  output logic                      in_ready,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [IDX_WL-1:0]         o_class,
  output logic [D_WL-1:0]           o_score
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 state;
  logic signed [D_WL-1:0] f_cls   [CLASS_NUM];
  logic signed [D_WL-1:0] vec_buf [CLASS_NUM];
  logic signed [D_WL-1:0] best_score;
  logic [IDX_WL-1:0]      best_idx;
  logic [IDX_WL-1:0]      cnt;
  logic signed [D_WL-1:0] cur;
  logic                   cur_gt;
  logic                   last;

  // Class 0 lives in the most significant slice of f_o.
  for (genvar gk = 0; gk < CLASS_NUM; gk++) begin : g_unpack
    assign f_cls[gk] = f_o[(CLASS_NUM-gk)*D_WL-1 -: D_WL];
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) vec_buf <= f_cls;
  end

  always_comb begin
    cur    = vec_buf[cnt];
    cur_gt = cur > best_score;
    last   = (cnt == IDX_WL'(CLASS_NUM - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      o_valid    <= 1'b0;
      o_class    <= '0;
      o_score    <= '0;
      cnt        <= '0;
      best_score <= '0;
      best_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            best_score <= f_cls[0];
            best_idx   <= '0;
            in_ready   <= 1'b0;
            if (CLASS_NUM == 1) begin
              cnt     <= '0;
              o_valid <= 1'b1;
              o_class <= '0;
              o_score <= f_cls[0];
              state   <= DONE;
            end else begin
              cnt   <= IDX_WL'(1);
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          // Strictly greater keeps the lowest index on ties.
          if (cur_gt) begin
            best_score <= cur;
            best_idx   <= cnt;
          end
          if (last) begin
            o_valid <= 1'b1;
            o_class <= cur_gt ? cnt : best_idx;
            o_score <= cur_gt ? cur : best_score;
            state   <= DONE;
          end else begin
            cnt <= cnt + IDX_WL'(1);
          end
        end
        DONE: begin
          if (o_ready) begin
            o_valid  <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax: reference argmax per accepted vector is queued
// and compared at each output handshake.
module tb_fc_argmax;

  localparam int CN = 30;
  localparam int DW = 16;
  localparam int IW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [CN*DW-1:0] f_o;
  logic             in_ready;
  logic             o_valid;
  logic             o_ready;
  logic [IW-1:0]    o_class;
  logic [DW-1:0]    o_score;

  fc_argmax #(.CLASS_NUM(CN), .D_WL(DW), .IDX_WL(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .f_o(f_o), .in_ready(in_ready),
    .o_valid(o_valid), .o_ready(o_ready), .o_class(o_class), .o_score(o_score)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [IW-1:0] cls; logic [DW-1:0] score; } exp_t;

  exp_t        sb[$];
  logic [15:0] sc [CN];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          pulses = 0;
  logic        prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard side: pop on every completed output handshake.
  always @(negedge clk) begin
    if (o_valid && !prev_valid) pulses++;
    prev_valid = o_valid;
    if (!rst && o_valid && o_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_underflow: got class %0d score %0h expected no result", o_class, o_score);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_class", 32'(o_class), 32'(e.cls));
        chk("sb_score", 32'(o_score), 32'(e.score));
      end
    end
  end

  function automatic logic [CN*DW-1:0] pack_vec();
    logic [CN*DW-1:0] v;
    for (int k = 0; k < CN; k++) v[(CN-1-k)*DW +: DW] = sc[k];
    return v;
  endfunction

  function automatic exp_t model();
    exp_t e;
    e.cls = '0;
    e.score = sc[0];
    for (int k = 1; k < CN; k++)
      if ($signed(sc[k]) > $signed(e.score)) begin
        e.cls = IW'(k);
        e.score = sc[k];
      end
    return e;
  endfunction

  task automatic fill(input logic [15:0] v);
    for (int k = 0; k < CN; k++) sc[k] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive sc[] and wait (bounded) for the accepting edge; returns cyc at that edge.
  task automatic accept_vec(input bit push, input bit keep, output int acc);
    int n;
    f_o = pack_vec();
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    tick();
    acc = cyc;
    if (push) sb.push_back(model());
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int n0, output int lat);
    int n;
    n = 0;
    while (!o_valid && n < 200) begin
      tick();
      n++;
    end
    if (!o_valid) chk("valid_timeout", 32'(o_valid), 32'd1);
    lat = cyc - n0;
  endtask

  int acc, acc2, lat, p0;
  logic [IW-1:0] hold_cls;
  logic [DW-1:0] hold_score;

  initial begin
    rst = 1'b1; in_valid = 1'b0; o_ready = 1'b0; f_o = '0;
    fill(16'h0000);
    tick(); tick();
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_class", 32'(o_class), 32'd0);
    chk("rst_o_score", 32'(o_score), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst = 1'b0;
    tick();

    // Ascending scores, latency and single-cycle handshake.
    o_ready = 1'b1;
    for (int k = 0; k < CN; k++) sc[k] = 16'(k * 256);
    accept_vec(1'b1, 1'b0, acc);
    chk("asc_valid_after_accept", 32'(o_valid), 32'd0);
    chk("asc_in_ready_low", 32'(in_ready), 32'd0);
    wait_valid(acc, lat);
    chk("asc_latency", 32'(lat), 32'd29);
    chk("asc_class", 32'(o_class), 32'd29);
    chk("asc_score", 32'(o_score), 32'h1D00);
    tick();
    chk("asc_valid_drop", 32'(o_valid), 32'd0);
    chk("asc_in_ready_back", 32'(in_ready), 32'd1);

    // Signed comparisons.
    fill(16'h0000); sc[5] = 16'h7FFF; sc[6] = 16'h8000;
    accept_vec(1'b1, 1'b0, acc);
    wait_valid(acc, lat);
    chk("sgn_class", 32'(o_class), 32'd5);
    chk("sgn_score", 32'(o_score), 32'h7FFF);
    tick();
    fill(16'hFF00); sc[0] = 16'hFFFF;
    accept_vec(1'b1, 1'b0, acc);
    wait_valid(acc, lat);
    chk("neg_class", 32'(o_class), 32'd0);
    chk("neg_score", 32'(o_score), 32'hFFFF);
    tick();

    // Tie resolves to the lower index.
    fill(16'h0000); sc[3] = 16'h0100; sc[17] = 16'h0100;
    accept_vec(1'b1, 1'b0, acc);
    wait_valid(acc, lat);
    chk("tie_class", 32'(o_class), 32'd3);
    chk("tie_score", 32'(o_score), 32'h0100);
    tick();

    // Backpressure with intruding vectors during SCAN and DONE.
    o_ready = 1'b0;
    fill(16'h0010); sc[9] = 16'h1234;
    accept_vec(1'b1, 1'b0, acc);
    repeat (5) tick();
    fill(16'h0000); sc[20] = 16'h7000;
    f_o = pack_vec(); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(acc, lat);
    chk("bp_latency", 32'(lat), 32'd29);
    chk("bp_class", 32'(o_class), 32'd9);
    chk("bp_score", 32'(o_score), 32'h1234);
    hold_cls = o_class; hold_score = o_score;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) in_valid = 1'b0;
      chk("bp_hold_valid", 32'(o_valid), 32'd1);
      chk("bp_hold_class", 32'(o_class), 32'(hold_cls));
      chk("bp_hold_score", 32'(o_score), 32'(hold_score));
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    o_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(o_valid), 32'd0);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    repeat (3) tick();
    chk("bp_no_second", 32'(o_valid), 32'd0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);

    // Reset mid-scan discards the pending result.
    for (int k = 0; k < CN; k++) sc[k] = 16'(k * 256);
    p0 = pulses;
    accept_vec(1'b0, 1'b0, acc);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_o_class", 32'(o_class), 32'd0);
    chk("mid_rst_o_score", 32'(o_score), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    @(negedge clk) rst = 1'b0;
    repeat (30) tick();
    chk("mid_rst_no_pulse", 32'(pulses), 32'(p0));
    fill(16'h0000); sc[12] = 16'h0400;
    accept_vec(1'b1, 1'b0, acc);
    wait_valid(acc, lat);
    chk("post_rst_class", 32'(o_class), 32'd12);
    chk("post_rst_score", 32'(o_score), 32'h0400);
    tick();

    // Back-to-back with in_valid held and o_ready tied high.
    p0 = pulses;
    fill(16'h0001); sc[7] = 16'h0300;
    accept_vec(1'b1, 1'b1, acc);
    fill(16'h0002); sc[22] = 16'h0500;
    accept_vec(1'b1, 1'b0, acc2);
    chk("b2b_spacing", 32'(acc2 - acc), 32'd31);
    wait_valid(acc2, lat);
    chk("b2b_class2", 32'(o_class), 32'd22);
    repeat (3) tick();
    chk("b2b_pulses", 32'(pulses - p0), 32'd2);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
